xnor_pop_accum: RTL
===================

Name: xnor_pop_accum

Overview:
- Sequential stage directly downstream of the 128-bit XNOR-popcount tree.
- Consumes one 8-bit popcount per 128-bit chunk of a binarized dot product.
- Accumulates chunks belonging to one neuron and applies the sign/threshold activation.
- Presents the neuron's total popcount and activation bit on a valid/ready output, one neuron per result.

Parameters:
- MAX_CHUNKS, 16, maximum 128-bit chunks per neuron (power of two, >=2)
- CNT_W, $clog2(MAX_CHUNKS)+1, width of the chunk counter
- ACC_W, 8+$clog2(MAX_CHUNKS), accumulator width (holds MAX_CHUNKS*128)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  popcount beat valid
- in_ready  out  1  stage can accept a beat
- in_pop  in  8  popcount of one 128-bit chunk, legal range 0..128
- in_last  in  1  marks the final chunk of the current neuron
- cfg_thresh  in  ACC_W  activation threshold, sampled on the first beat of a neuron
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_pop  out  ACC_W  total popcount of the neuron
- out_act  out  1  activation bit: 1 when out_pop >= threshold
- out_chunks  out  CNT_W  number of chunks accumulated (1..MAX_CHUNKS)
- out_err  out  1  overflow or illegal-popcount flag for this result

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, acc=0, cnt=0, thresh_q=0.
  - All outputs 0; in_ready=0 while rst_n is low, 1 after release.
- Beat accepted when in_valid && in_ready. in_ready=1 in IDLE and ACCUM, 0 in DONE.
- States IDLE, ACCUM, DONE.
- IDLE, beat accepted:
  - acc=pop_c, cnt=1, thresh_q=cfg_thresh, err_q=illegal.
  - Go to ACCUM, or DONE when the beat is final.
- ACCUM, beat accepted:
  - acc=acc+pop_c, cnt=cnt+1, err_q|=illegal.
  - Go to DONE when the beat is final, else stay in ACCUM.
  - No beat: hold all registers.
- pop_c = in_pop clamped to 128. illegal = (in_pop>128).
- A beat is final when in_last=1 OR cnt+1==MAX_CHUNKS.
  - Forced final (in_last=0 on the MAX_CHUNKS-th beat) sets err.
  - The following beats belong to the next neuron.
- Entry to DONE registers all outputs in the same edge:
  - out_pop = final sum.
  - out_act = (final sum >= thresh_q), unsigned compare.
  - out_chunks = final count, out_err = accumulated err.
  - out_valid=1.
- Latency: result visible the cycle after the final beat is accepted.
- DONE:
  - Outputs held stable while out_valid && !out_ready.
  - On out_ready: out_valid=0, state=IDLE; in_ready rises the next cycle (no same-cycle bypass).
  - Other outputs keep their last values after acceptance.
- Width rule: acc never wraps. MAX_CHUNKS*128 = 2^(ACC_W-1) fits in ACC_W bits.
- Changes on cfg_thresh mid-neuron have no effect; only the first-beat sample is used.
- in_pop/in_last are ignored when no beat is accepted.
- rst_n low mid-neuron or in DONE: the result is discarded and all registers clear immediately.

Decomposition:
- Shared package bnn_pkg:
  - POP_W=8, POP_MAX=128.
  - State enum {IDLE, ACCUM, DONE}.
  - Function computing ACC_W from MAX_CHUNKS.
- No sub-module. FSM and datapath are small and live in one module.
- The combinational popcount tree stays a separate upstream instance.

Test Plan:
- Single-beat neuron: in_pop=100, in_last=1, cfg_thresh=64.
  -> Next cycle out_valid=1, out_pop=100, out_act=1, out_chunks=1, out_err=0.
- Four beats 128,0,64,7, last on 4th, thresh=200.
  -> out_pop=199, out_act=0, out_chunks=4; in_ready=0 until out_ready is seen, then 1 the following cycle.
- Backpressure: out_ready=0 for 5 cycles after the result.
  -> Outputs stable; in_valid beats not accepted; on out_ready=1 a new neuron starts cleanly (acc restarts, not adds).
- Overflow: 16 beats of 128 with in_last=0.
  -> out_pop=2048, out_chunks=16, out_err=1; the 17th beat starts a new neuron with cnt=1.
- Illegal input: in_pop=200 then in_pop=10 with last.
  -> out_pop=138, out_err=1. Changing cfg_thresh during beat 2 does not alter out_act.
- Assert rst_n=0 mid-ACCUM after 3 beats.
  -> Outputs 0 immediately; after release, a single beat of 5 with last gives out_pop=5.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared definitions for the binarized-network datapath stages.
package bnn_pkg;

    localparam int POP_W = 8;
    localparam logic [POP_W-1:0] POP_MAX = 8'd128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Accumulator width able to hold max_chunks * POP_MAX without wrapping.
    function automatic int acc_width(input int max_chunks);
        return POP_W + $clog2(max_chunks);
    endfunction

endpackage

// File: rtl/xnor_pop_accum.sv
// Accumulates per-chunk XNOR popcounts for one neuron and applies the
// threshold activation, presenting one result per neuron on a valid/ready port.
module xnor_pop_accum
    import bnn_pkg::*;
#(
    parameter int MAX_CHUNKS = 16,
    parameter int CNT_W      = $clog2(MAX_CHUNKS) + 1,
    parameter int ACC_W      = acc_width(MAX_CHUNKS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [POP_W-1:0] in_pop,
    input  logic             in_last,
    input  logic [ACC_W-1:0] cfg_thresh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_pop,
    output logic             out_act,
    output logic [CNT_W-1:0] out_chunks,
    output logic             out_err
);

    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_CHUNKS);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] thresh_q;
    logic [CNT_W-1:0] cnt;
    logic             err_q;

    logic             accept;
    logic             illegal;
    logic [POP_W-1:0] pop_c;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt_nxt;
    logic [ACC_W-1:0] thresh_eff;
    logic             at_cap;
    logic             final_beat;
    logic             err_nxt;

    // in_ready is low while reset is held, so it cannot be a plain register.
    assign in_ready = rst_n && (state != DONE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        illegal    = in_pop > POP_MAX;
        pop_c      = illegal ? POP_MAX : in_pop;
        // A beat taken in IDLE starts a fresh neuron rather than adding to stale state.
        sum        = ((state == IDLE) ? '0 : acc) + {{(ACC_W-POP_W){1'b0}}, pop_c};
        cnt_nxt    = ((state == IDLE) ? '0 : cnt) + 1'b1;
        thresh_eff = (state == IDLE) ? cfg_thresh : thresh_q;
        at_cap     = (cnt_nxt == CNT_CAP);
        final_beat = in_last || at_cap;
        err_nxt    = ((state == IDLE) ? 1'b0 : err_q) | illegal | (at_cap && !in_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            thresh_q   <= '0;
            err_q      <= 1'b0;
            out_valid  <= 1'b0;
            out_pop    <= '0;
            out_act    <= 1'b0;
            out_chunks <= '0;
            out_err    <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc   <= sum;
                        cnt   <= cnt_nxt;
                        err_q <= err_nxt;
                        if (state == IDLE) begin
                            thresh_q <= cfg_thresh;
                        end
                        if (final_beat) begin
                            state      <= DONE;
                            out_valid  <= 1'b1;
                            out_pop    <= sum;
                            out_act    <= (sum >= thresh_eff);
                            out_chunks <= cnt_nxt;
                            out_err    <= err_nxt;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
